// File: rtl/fe_pattern_chk.sv
// fe_pattern_chk: self-synchronising ramp / PRBS7 checker on the deserialised front-end bus.
// Define FE_CHK_FIRST_ERR_EN to add first-error capture ports (o_ferr_*).
//
// state | meaning
// IDLE  | checker disabled, counters held
// PRIME | loading history from PrimeCycles valid cycles
// CHECK | judging every valid cycle against the recurrence
module fe_pattern_chk #(
  parameter int LaneWidth   = 8,
  parameter int AdcWidth    = 6,
  parameter int DesOutWidth = 4,
  parameter int ErrCntWidth = 16,
  parameter int PrimeCycles = 2
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic [LaneWidth*DesOutWidth-1:0][AdcWidth-1:0]   i_dat,
  input  logic                                             i_vld,
  input  logic                                             i_en,
  input  logic                                             i_mode,
  input  logic                                             i_clr,
  output logic [1:0]                                       o_state,
  output logic [LaneWidth-1:0][ErrCntWidth-1:0]            o_err_cnt,
  output logic                                             o_err_any,
  output logic [31:0]                                      o_chk_cnt
`ifdef FE_CHK_FIRST_ERR_EN
  ,
  output logic                                             o_ferr_vld,
  output logic [$clog2(LaneWidth*DesOutWidth)-1:0]         o_ferr_idx,
  output logic [AdcWidth-1:0]                              o_ferr_dat,
  output logic [31:0]                                      o_ferr_cyc
`endif
);

  localparam int NumSmp   = LaneWidth * DesOutWidth;
  localparam int LaneErrW = $clog2(DesOutWidth + 1);
  localparam int PrimeW   = $clog2(PrimeCycles + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    CHECK = 2'b10
  } state_t;

  state_t                                  state_q, state_d;
  logic [PrimeW-1:0]                       prime_q, prime_d;
  logic [AdcWidth-1:0]                     hist_samp_q;
  logic [6:0]                              hist_prbs_q;
  logic [LaneWidth-1:0][ErrCntWidth-1:0]   err_cnt_q;
  logic                                    err_any_q;
  logic [31:0]                             chk_cnt_q;

  logic                                    clr_cnt;
  logic                                    hist_ld;
  logic                                    chk_upd;

  logic [NumSmp-1:0][AdcWidth-1:0]         prev_smp;
  logic [NumSmp+6:0]                       msb_ext;
  logic [NumSmp-1:0]                       smp_err;
  logic [LaneWidth-1:0][LaneErrW-1:0]      lane_hits;
  logic [LaneWidth-1:0][ErrCntWidth:0]     lane_sum;
  logic [LaneWidth-1:0][ErrCntWidth-1:0]   err_cnt_nxt;

  // Every sample is judged against the received predecessors, so one bad
  // sample only disturbs the few comparisons that reference it.
  always_comb begin
    prev_smp    = '0;
    msb_ext     = '0;
    smp_err     = '0;
    prev_smp[0] = hist_samp_q;
    for (int n = 1; n < NumSmp; n++)
      prev_smp[n] = i_dat[n-1];
    msb_ext[6:0] = hist_prbs_q;
    for (int n = 0; n < NumSmp; n++)
      msb_ext[n+7] = i_dat[n][AdcWidth-1];
    for (int n = 0; n < NumSmp; n++) begin
      if (i_mode)
        smp_err[n] = msb_ext[n+7] ^ msb_ext[n] ^ msb_ext[n+1];
      else
        smp_err[n] = (i_dat[n] != AdcWidth'(prev_smp[n] + AdcWidth'(1)));
    end
  end

  always_comb begin
    lane_hits   = '0;
    lane_sum    = '0;
    err_cnt_nxt = '0;
    for (int l = 0; l < LaneWidth; l++) begin
      for (int j = 0; j < DesOutWidth; j++)
        lane_hits[l] = lane_hits[l] + LaneErrW'(smp_err[l + j*LaneWidth]);
      lane_sum[l]    = {1'b0, err_cnt_q[l]} + (ErrCntWidth+1)'(lane_hits[l]);
      err_cnt_nxt[l] = lane_sum[l][ErrCntWidth] ? '1 : lane_sum[l][ErrCntWidth-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    clr_cnt = 1'b0;
    hist_ld = 1'b0;
    chk_upd = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
    end else if (i_clr) begin
      state_d = PRIME;
      prime_d = PrimeW'(PrimeCycles);
      clr_cnt = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRIME;
          prime_d = PrimeW'(PrimeCycles);
        end
        PRIME: begin
          if (i_vld) begin
            hist_ld = 1'b1;
            prime_d = PrimeW'(prime_q - PrimeW'(1));
            if (prime_q == PrimeW'(1))
              state_d = CHECK;
          end
        end
        CHECK: begin
          if (i_vld) begin
            hist_ld = 1'b1;
            chk_upd = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      prime_q     <= '0;
      hist_samp_q <= '0;
      hist_prbs_q <= '0;
      err_cnt_q   <= '0;
      err_any_q   <= 1'b0;
      chk_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      if (hist_ld) begin
        hist_samp_q <= i_dat[NumSmp-1];
        hist_prbs_q <= msb_ext[NumSmp+6:NumSmp];
      end
      if (clr_cnt) begin
        err_cnt_q <= '0;
        err_any_q <= 1'b0;
        chk_cnt_q <= '0;
      end else if (chk_upd) begin
        err_cnt_q <= err_cnt_nxt;
        if (|smp_err)
          err_any_q <= 1'b1;
        if (chk_cnt_q != '1)
          chk_cnt_q <= chk_cnt_q + 32'd1;
      end
    end
  end

  assign o_state   = state_q;
  assign o_err_cnt = err_cnt_q;
  assign o_err_any = err_any_q;
  assign o_chk_cnt = chk_cnt_q;

`ifdef FE_CHK_FIRST_ERR_EN
  localparam int IdxW = $clog2(NumSmp);

  logic [IdxW-1:0]     ferr_idx_d;
  logic                ferr_vld_q;
  logic [IdxW-1:0]     ferr_idx_q;
  logic [AdcWidth-1:0] ferr_dat_q;
  logic [31:0]         ferr_cyc_q;

  // Descending scan so the lowest failing sample wins.
  always_comb begin
    ferr_idx_d = '0;
    for (int n = NumSmp - 1; n >= 0; n--)
      if (smp_err[n])
        ferr_idx_d = IdxW'(n);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
      ferr_dat_q <= '0;
      ferr_cyc_q <= '0;
    end else if (clr_cnt) begin
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
      ferr_dat_q <= '0;
      ferr_cyc_q <= '0;
    end else if (chk_upd && (|smp_err) && !ferr_vld_q) begin
      ferr_vld_q <= 1'b1;
      ferr_idx_q <= ferr_idx_d;
      ferr_dat_q <= i_dat[ferr_idx_d];
      ferr_cyc_q <= chk_cnt_q;
    end
  end

  assign o_ferr_vld = ferr_vld_q;
  assign o_ferr_idx = ferr_idx_q;
  assign o_ferr_dat = ferr_dat_q;
  assign o_ferr_cyc = ferr_cyc_q;
`endif

endmodule

// File: tb/tb_fe_pattern_chk.sv
// Bench for fe_pattern_chk: flat-stream reference model feeding a scoreboard of expected outputs.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_fe_pattern_chk;
  localparam int LW = 8;
  localparam int AW = 6;
  localparam int DW = 4;
  localparam int NS = LW * DW;
  localparam int EW = 16;
  localparam int SW = 4;
  localparam int PC = 2;
`ifdef FE_CHK_FIRST_ERR_EN
  localparam int SNAP_W = 2 + 1 + 32 + LW*EW + LW*SW + 1 + 5 + AW + 32;
`else
  localparam int SNAP_W = 2 + 1 + 32 + LW*EW + LW*SW;
`endif

  typedef logic [NS-1:0][AW-1:0] word_t;
  typedef logic [SNAP_W-1:0]     snap_t;

  logic clk = 1'b0;
  logic rst, vld, en, mode, clr;
  word_t dat;
  logic [1:0] st, s_st;
  logic [LW-1:0][EW-1:0] err_cnt;
  logic [LW-1:0][SW-1:0] s_err_cnt;
  logic err_any, s_err_any;
  logic [31:0] chk_cnt, s_chk_cnt;
`ifdef FE_CHK_FIRST_ERR_EN
  logic ferr_vld, s_ferr_vld;
  logic [4:0] ferr_idx, s_ferr_idx;
  logic [AW-1:0] ferr_dat, s_ferr_dat;
  logic [31:0] ferr_cyc, s_ferr_cyc;
`endif

  always #5 clk = ~clk;

  fe_pattern_chk #(.LaneWidth(LW), .AdcWidth(AW), .DesOutWidth(DW),
                   .ErrCntWidth(EW), .PrimeCycles(PC)) dut (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_vld(vld), .i_en(en),
    .i_mode(mode), .i_clr(clr), .o_state(st), .o_err_cnt(err_cnt),
    .o_err_any(err_any), .o_chk_cnt(chk_cnt)
`ifdef FE_CHK_FIRST_ERR_EN
    , .o_ferr_vld(ferr_vld), .o_ferr_idx(ferr_idx), .o_ferr_dat(ferr_dat), .o_ferr_cyc(ferr_cyc)
`endif
  );

  fe_pattern_chk #(.LaneWidth(LW), .AdcWidth(AW), .DesOutWidth(DW),
                   .ErrCntWidth(SW), .PrimeCycles(PC)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_vld(vld), .i_en(en),
    .i_mode(mode), .i_clr(clr), .o_state(s_st), .o_err_cnt(s_err_cnt),
    .o_err_any(s_err_any), .o_chk_cnt(s_chk_cnt)
`ifdef FE_CHK_FIRST_ERR_EN
    , .o_ferr_vld(s_ferr_vld), .o_ferr_idx(s_ferr_idx), .o_ferr_dat(s_ferr_dat), .o_ferr_cyc(s_ferr_cyc)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  snap_t sb[$];

  // reference model: flat stream of received samples since entering PRIME
  int m_state, m_prime, m_chk;
  int m_cnt[LW];
  bit m_any;
  int m_stream[$];
  bit m_fvld;
  int m_fidx, m_fdat, m_fcyc;

  function automatic void model_reset();
    m_state = 0; m_prime = 0; m_chk = 0; m_any = 1'b0;
    for (int l = 0; l < LW; l++) m_cnt[l] = 0;
    m_stream.delete();
    m_fvld = 1'b0; m_fidx = 0; m_fdat = 0; m_fcyc = 0;
  endfunction

  function automatic snap_t exp_snap();
    logic [LW-1:0][EW-1:0] c;
    logic [LW-1:0][SW-1:0] cs;
    for (int l = 0; l < LW; l++) begin
      c[l]  = (m_cnt[l] > 65535) ? '1 : EW'(m_cnt[l]);
      cs[l] = (m_cnt[l] > 15) ? '1 : SW'(m_cnt[l]);
    end
`ifdef FE_CHK_FIRST_ERR_EN
    return {2'(m_state), m_any, 32'(m_chk), c, cs, m_fvld, 5'(m_fidx), 6'(m_fdat), 32'(m_fcyc)};
`else
    return {2'(m_state), m_any, 32'(m_chk), c, cs};
`endif
  endfunction

  function automatic snap_t act_snap();
`ifdef FE_CHK_FIRST_ERR_EN
    return {st, err_any, chk_cnt, err_cnt, s_err_cnt, ferr_vld, ferr_idx, ferr_dat, ferr_cyc};
`else
    return {st, err_any, chk_cnt, err_cnt, s_err_cnt};
`endif
  endfunction

  function automatic word_t ramp_word(input int start);
    word_t w;
    for (int n = 0; n < NS; n++) w[n] = AW'((start + n) % 64);
    return w;
  endfunction

  // drives one cycle of stimulus and pushes the outputs expected after the next edge
  task automatic drive(input bit e, input bit v, input bit c, input bit md, input word_t d);
    int k, s, eb;
    bit err, hit;
    en = e; vld = v; clr = c; mode = md; dat = d;
    if (!e) begin
      m_state = 0;
    end else if (c) begin
      for (int l = 0; l < LW; l++) m_cnt[l] = 0;
      m_chk = 0; m_any = 1'b0; m_fvld = 1'b0; m_fidx = 0; m_fdat = 0; m_fcyc = 0;
      m_state = 1; m_prime = PC; m_stream.delete();
    end else if (m_state == 0) begin
      m_state = 1; m_prime = PC; m_stream.delete();
    end else if (v && m_state == 1) begin
      for (int n = 0; n < NS; n++) m_stream.push_back(int'(d[n]));
      m_prime--;
      if (m_prime == 0) m_state = 2;
    end else if (v && m_state == 2) begin
      hit = 1'b0;
      for (int n = 0; n < NS; n++) begin
        k = m_stream.size();
        s = int'(d[n]);
        if (md) begin
          eb  = ((m_stream[k-7] >> 5) & 1) ^ ((m_stream[k-6] >> 5) & 1);
          err = ((s >> 5) & 1) != eb;
        end else begin
          err = s != ((m_stream[k-1] + 1) % 64);
        end
        m_stream.push_back(s);
        if (err) begin
          m_cnt[n % LW]++;
          m_any = 1'b1;
          if (!m_fvld && !hit) begin
            hit = 1'b1; m_fidx = n; m_fdat = s; m_fcyc = m_chk;
          end
        end
      end
      if (hit) m_fvld = 1'b1;
      m_chk++;
    end
    while (m_stream.size() > 8) void'(m_stream.pop_front());
    sb.push_back(exp_snap());
  endtask

  task automatic test_reset();
    snap_t got;
    rst = 1'b1; en = 1'b0; vld = 1'b0; clr = 1'b0; mode = 1'b0; dat = '0;
    model_reset();
    repeat (2) @(negedge clk);
    got = act_snap(); n_assert++;
    if (got !== '0) begin n_fail++; $display("FAIL reset got=%h want=0", got); end
    rst = 1'b0;
  endtask

  task automatic test_ramp_clean();
    snap_t got, want;
    drive(1, 0, 0, 0, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL ramp_clean enable got=%h want=%h", got, want); end
    for (int c = 0; c < 100; c++) begin
      drive(1, 1, 0, 0, ramp_word(c * NS)); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL ramp_clean c%0d got=%h want=%h", c, got, want); end
      if (c == 1) begin
        n_assert++;
        if (st !== 2'b10) begin n_fail++; $display("FAIL prime_to_check got=%b want=10", st); end
      end
    end
    n_assert++;
    if (chk_cnt !== 32'd98) begin n_fail++; $display("FAIL ramp_chk_cnt got=%0d want=98", chk_cnt); end
    n_assert++;
    if (err_cnt !== '0 || err_any !== 1'b0) begin
      n_fail++; $display("FAIL ramp_no_err got=%h/%b want=0/0", err_cnt, err_any);
    end
  endtask

  task automatic test_ramp_corrupt();
    snap_t got, want;
    word_t w;
    logic [LW-1:0][EW-1:0] exp_cnt;
    drive(1, 0, 1, 0, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL ramp_corrupt clr got=%h want=%h", got, want); end
    for (int c = 0; c < 20; c++) begin
      w = ramp_word(c * NS);
      if (c == 10) w[5] = 6'h3F;
      drive(1, 1, 0, 0, w); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL ramp_corrupt c%0d got=%h want=%h", c, got, want); end
    end
    exp_cnt = '0; exp_cnt[5] = 16'd1; exp_cnt[6] = 16'd1;
    n_assert++;
    if (err_cnt !== exp_cnt) begin n_fail++; $display("FAIL ramp_corrupt_lanes got=%h want=%h", err_cnt, exp_cnt); end
    n_assert++;
    if (err_any !== 1'b1) begin n_fail++; $display("FAIL ramp_err_any got=%b want=1", err_any); end
  endtask

  task automatic test_prbs_gaps();
    snap_t got, want;
    word_t w;
    logic [6:0] g;
    bit v, b;
    int tot;
    g = 7'h5A;
    drive(1, 0, 1, 1, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL prbs clr got=%h want=%h", got, want); end
    for (int c = 0; c < 30; c++) begin
      v = (c % 3) != 2;
      for (int n = 0; n < NS; n++) begin
        if (v) begin
          b = g[0] ^ g[1];
          g = {b, g[6:1]};
          w[n] = {b, 5'($urandom)};
        end else begin
          w[n] = 6'($urandom);
        end
      end
      if (c == 21) begin
        n_assert++;
        if (err_any !== 1'b0) begin n_fail++; $display("FAIL prbs_clean got=%b want=0", err_any); end
        w[0][5] = ~w[0][5];
      end
      drive(1, v, 0, 1, w); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL prbs c%0d got=%h want=%h", c, got, want); end
    end
    tot = 0;
    for (int l = 0; l < LW; l++) tot += int'(err_cnt[l]);
    n_assert++;
    if (tot != 3) begin n_fail++; $display("FAIL prbs_flip_total got=%0d want=3", tot); end
  endtask

  task automatic test_saturation();
    snap_t got, want;
    logic [LW-1:0][SW-1:0] full;
    logic [LW-1:0][EW-1:0] exp72;
    drive(1, 0, 1, 0, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL sat clr got=%h want=%h", got, want); end
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 0, 0, '0); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL sat c%0d got=%h want=%h", c, got, want); end
    end
    full = '1;
    for (int l = 0; l < LW; l++) exp72[l] = 16'd72;
    n_assert++;
    if (s_err_cnt !== full) begin n_fail++; $display("FAIL sat_4bit got=%h want=%h", s_err_cnt, full); end
    n_assert++;
    if (err_cnt !== exp72) begin n_fail++; $display("FAIL sat_16bit got=%h want=%h", err_cnt, exp72); end
  endtask

  task automatic test_enable_clear();
    snap_t got, want;
    logic [LW-1:0][EW-1:0] held;
    held = err_cnt;
    drive(0, 1, 0, 0, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL disable got=%h want=%h", got, want); end
    n_assert++;
    if (st !== 2'b00 || err_cnt !== held) begin
      n_fail++; $display("FAIL disable_hold got=%b/%h want=00/%h", st, err_cnt, held);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, c != 0, 0, 0, '0); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL reenable c%0d got=%h want=%h", c, got, want); end
    end
    drive(1, 1, 1, 0, ramp_word(7)); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL clr_mid got=%h want=%h", got, want); end
    n_assert++;
    if (err_cnt !== '0 || chk_cnt !== '0 || err_any !== 1'b0 || st !== 2'b01) begin
      n_fail++; $display("FAIL clr_mid_state got=%h/%0d/%b/%b want=0/0/0/01", err_cnt, chk_cnt, err_any, st);
    end
  endtask

  task automatic test_async_reset();
    snap_t got, want;
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 0, 0, ramp_word(c * NS)); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL pre_rst c%0d got=%h want=%h", c, got, want); end
    end
    drive(1, 1, 0, 0, '0);
    #2 rst = 1'b1;
    #1;
    got = act_snap(); n_assert++;
    if (got !== '0) begin n_fail++; $display("FAIL async_reset got=%h want=0", got); end
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1, c != 0, 0, 0, ramp_word(c * NS)); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL post_rst c%0d got=%h want=%h", c, got, want); end
    end
  endtask

`ifdef FE_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    snap_t got, want;
    word_t w;
    drive(1, 0, 1, 0, '0); @(negedge clk);
    got = act_snap(); want = sb.pop_front(); n_assert++;
    if (got !== want) begin n_fail++; $display("FAIL ferr clr got=%h want=%h", got, want); end
    for (int c = 0; c < 20; c++) begin
      w = ramp_word(c * NS);
      if (c == 12) w[9] = w[9] ^ 6'h15;
      if (c == 15) w[2] = w[2] ^ 6'h15;
      drive(1, 1, 0, 0, w); @(negedge clk);
      got = act_snap(); want = sb.pop_front(); n_assert++;
      if (got !== want) begin n_fail++; $display("FAIL ferr c%0d got=%h want=%h", c, got, want); end
    end
    n_assert++;
    if (ferr_vld !== 1'b1 || ferr_idx !== 5'd9 || ferr_cyc !== 32'd10 || ferr_dat !== 6'h1C) begin
      n_fail++;
      $display("FAIL ferr_latch got=%b/%0d/%0d/%h want=1/9/10/1c", ferr_vld, ferr_idx, ferr_cyc, ferr_dat);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_clean();
    test_ramp_corrupt();
    test_prbs_gaps();
    test_saturation();
    test_enable_clear();
    test_async_reset();
`ifdef FE_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
